// File: rtl/alarmclock_defs_pkg.sv
// rtl/alarmclock_defs_pkg.sv - shared BCD limits, time_bcd field positions and reset time
package alarmclock_defs;

    localparam logic [7:0]  SEC_MAX  = 8'h59;
    localparam logic [7:0]  MIN_MAX  = 8'h59;
    localparam logic [7:0]  HOUR_MAX = 8'h23;

    localparam int HOUR_HI = 15;
    localparam int HOUR_LO = 8;
    localparam int MIN_HI  = 7;
    localparam int MIN_LO  = 0;

    localparam logic [15:0] DEFAULT_RESET_TIME = 16'h1200;

    // Two-digit BCD increment with wrap at max; each digit is stepped on its own.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] val, input logic [7:0] max);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = val[7:4];
        units = val[3:0];
        if (val == max) begin
            return 8'h00;
        end else if (units == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end else begin
            return {tens, units + 4'd1};
        end
    endfunction

endpackage

// File: rtl/time_counter_bcd_mod_counter.sv
// rtl/time_counter_bcd_mod_counter.sv - two-digit BCD counter 00..MAX with carry out
module bcd_mod_counter
    import alarmclock_defs::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rst_val,
    input  logic       inc,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= rst_val;
        end else if (inc) begin
            value <= bcd_inc2(value, MAX);
        end
    end

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - live HH:MM:SS time-of-day counter with set mode
module time_counter
    import alarmclock_defs::*;
#(
    parameter int          CLK_DIV    = 50000000,
    parameter logic [15:0] RESET_TIME = DEFAULT_RESET_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic        inc_min,
    input  logic        inc_hour,
    output logic [15:0] time_bcd,
    output logic [7:0]  sec_bcd,
    output logic        sec_tick,
    output logic        min_tick
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] presc;
    logic          sec_edge;
    logic          sec_carry;
    logic          min_carry;
    logic          min_inc;
    logic          hour_inc;
    logic [7:0]    min_val;
    logic [7:0]    hour_val;

    assign sec_edge = !set_en && (presc == PW'(CLK_DIV - 1));

    // Prescaler restarts from zero whenever set mode is active, so resume is a full second.
    always_ff @(posedge clk) begin
        if (rst || set_en || sec_edge) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst || set_en),
        .rst_val (8'h00),
        .inc     (sec_edge),
        .value   (sec_bcd),
        .carry   (sec_carry)
    );

    assign min_inc = sec_carry || (set_en && inc_min);

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_TIME[MIN_HI:MIN_LO]),
        .inc     (min_inc),
        .value   (min_val),
        .carry   (min_carry)
    );

    // Minute wrap from a set-mode button must not bump the hour.
    assign hour_inc = (min_carry && !set_en) || (set_en && inc_hour);

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_TIME[HOUR_HI:HOUR_LO]),
        .inc     (hour_inc),
        .value   (hour_val),
        .carry   ()
    );

    assign time_bcd = {hour_val, min_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
        end else begin
            sec_tick <= sec_edge;
            min_tick <= sec_carry;
        end
    end

endmodule
